// File: rtl/freq_meter_pkg.sv
// Shared types and BCD constants for the gated-window frequency meter.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        GATE  = 2'd2,
        LATCH = 2'd3
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

endpackage

// File: rtl/freq_meter_bcd_digit.sv
// One decade of the BCD edge counter: clear, increment with 9->0 rollover,
// and a carry that is high whenever this digit is asked to step past 9.
module bcd_digit
    import freq_meter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    input  logic       sat,
    output logic [3:0] digit,
    output logic       carry
);

    assign carry = inc & (digit == BCD_NINE);

    // sat freezes every decade once the whole counter reads all-9s
    always_ff @(posedge clk) begin
        if (!rst) begin
            digit <= BCD_ZERO;
        end else if (clr) begin
            digit <= BCD_ZERO;
        end else if (inc && !sat) begin
            digit <= (digit == BCD_NINE) ? BCD_ZERO : digit + 4'd1;
        end
    end

endmodule

// File: rtl/freq_meter.sv
// Gated-window frequency meter: counts sig_in rising edges over GATE_CYCLES clk
// cycles into packed BCD. Define FREQ_METER_OVF_EN for saturation plus an ovf port.
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int GATE_CYCLES = 1000,
    parameter int DIGITS      = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                sig_in,
    output logic                busy,
    output logic                done,
    output logic [4*DIGITS-1:0] bcd
`ifdef FREQ_METER_OVF_EN
    ,
    output logic                ovf
`endif
);

    localparam int            GW        = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);

    state_t              state;
    state_t              state_nxt;
    logic                s1;
    logic                s2;
    logic                s3;
    logic                sig_edge;
    logic [GW-1:0]       gate_cnt;
    logic [4*DIGITS-1:0] count;
    logic [DIGITS:0]     carry;
    logic                cnt_clr;
    logic                cnt_inc;
    logic                sat;

    // Two-flop synchronizer, then one delay stage for rising-edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign sig_edge = s2 & ~s3;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ARM;
            ARM:     state_nxt = GATE;
            GATE:    if (gate_cnt == GATE_LAST) state_nxt = LATCH;
            LATCH:   state_nxt = start ? ARM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state == ARM) || (state == GATE);
        cnt_clr = (state == ARM);
        cnt_inc = (state == GATE) && sig_edge;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            gate_cnt <= '0;
        end else if (state == ARM) begin
            gate_cnt <= '0;
        end else if (state == GATE) begin
            gate_cnt <= gate_cnt + 1'b1;
        end
    end

    assign carry[0] = cnt_inc;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk   (clk),
            .rst   (rst),
            .clr   (cnt_clr),
            .inc   (carry[i]),
            .sat   (sat),
            .digit (count[4*i +: 4]),
            .carry (carry[i+1])
        );
    end

`ifdef FREQ_METER_OVF_EN
    logic all_nine;
    logic ovf_int;

    always_comb begin
        all_nine = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (count[4*i +: 4] != BCD_NINE) all_nine = 1'b0;
        end
    end

    assign sat = all_nine;

    // The top decade's carry fires exactly when an edge arrives at all-9s
    always_ff @(posedge clk) begin
        if (!rst) begin
            ovf_int <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            if (state == ARM) begin
                ovf_int <= 1'b0;
            end else if (carry[DIGITS]) begin
                ovf_int <= 1'b1;
            end
            if (state == LATCH) ovf <= ovf_int;
        end
    end
`else
    logic carry_unused;

    assign sat          = 1'b0;
    assign carry_unused = carry[DIGITS];
`endif

    // Result is published at the clock edge that ends LATCH
    always_ff @(posedge clk) begin
        if (!rst) begin
            done <= 1'b0;
            bcd  <= '0;
        end else begin
            done <= (state == LATCH);
            if (state == LATCH) bcd <= count;
        end
    end

endmodule

// File: tb/tb_freq_meter.sv
// Directed bench for freq_meter (GATE_CYCLES=1000 with 4 and 2 digits);
// expectations follow FREQ_METER_OVF_EN when it is defined.
module tb_freq_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        sig_in = 1'b0;
    logic        busy;
    logic        done;
    logic [15:0] bcd;
    logic        busy2;
    logic        done2;
    logic [7:0]  bcd2;
`ifdef FREQ_METER_OVF_EN
    logic        ovf;
    logic        ovf2;
`endif

    int   checks = 0;
    int   errors = 0;
    int   sig_period = 0;
    logic sig_level = 1'b0;

    always #5 clk = ~clk;

    freq_meter #(.GATE_CYCLES(1000), .DIGITS(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sig_in (sig_in),
        .busy   (busy),
        .done   (done),
        .bcd    (bcd)
`ifdef FREQ_METER_OVF_EN
        ,
        .ovf    (ovf)
`endif
    );

    freq_meter #(.GATE_CYCLES(1000), .DIGITS(2)) dut2 (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .sig_in (sig_in),
        .busy   (busy2),
        .done   (done2),
        .bcd    (bcd2)
`ifdef FREQ_METER_OVF_EN
        ,
        .ovf    (ovf2)
`endif
    );

    // Square-wave source: period in clk cycles, or a static level when period is 0
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            if (sig_period == 0) begin
                sig_in = sig_level;
            end else begin
                ph     = (ph + 1) % sig_period;
                sig_in = (ph < sig_period / 2);
            end
        end
    end

    task automatic pulse_start;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    // n = posedges after the one that sampled start; bounded at 1300
    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 1300);
    endtask

    task automatic test_reset;
        rst        = 1'b0;
        sig_period = 2;
        repeat (3) begin
            @(negedge clk);
            checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
            checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
            checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL reset_bcd: got %h want 0000", bcd); end
        end
        rst = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_count;
        int n;
        sig_period = 10;
        repeat (5) @(negedge clk);
        pulse_start();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL count_busy_arm: got %b want 1", busy); end
        wait_done(n);
        checks++; if (n != 1002) begin errors++; $display("FAIL count_latency: got %0d want 1002", n); end
        checks++; if (bcd !== 16'h0100) begin errors++; $display("FAIL count_bcd: got %h want 0100", bcd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL count_busy_after: got %b want 0", busy); end
`ifdef FREQ_METER_OVF_EN
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL count_ovf: got %b want 0", ovf); end
`endif
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL count_done_width: got %b want 0", done); end
        checks++; if (bcd !== 16'h0100) begin errors++; $display("FAIL count_bcd_hold: got %h want 0100", bcd); end
    endtask

    task automatic test_no_edge;
        int n;
        sig_period = 0;
        sig_level  = 1'b0;
        repeat (10) @(negedge clk);
        pulse_start();
        wait_done(n);
        checks++; if (n != 1002) begin errors++; $display("FAIL low_latency: got %0d want 1002", n); end
        checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL low_bcd: got %h want 0000", bcd); end
        sig_level = 1'b1;
        repeat (10) @(negedge clk);
        pulse_start();
        wait_done(n);
        checks++; if (n != 1002) begin errors++; $display("FAIL high_latency: got %0d want 1002", n); end
        checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL high_bcd: got %h want 0000", bcd); end
    endtask

    task automatic test_overflow;
        int n;
        sig_period = 4;
        repeat (5) @(negedge clk);
        pulse_start();
        wait_done(n);
        checks++; if (bcd !== 16'h0250) begin errors++; $display("FAIL ovf4_bcd: got %h want 0250", bcd); end
        checks++; if (done2 !== 1'b1) begin errors++; $display("FAIL ovf2_done: got %b want 1", done2); end
`ifdef FREQ_METER_OVF_EN
        checks++; if (bcd2 !== 8'h99) begin errors++; $display("FAIL ovf2_bcd: got %h want 99", bcd2); end
        checks++; if (ovf2 !== 1'b1) begin errors++; $display("FAIL ovf2_flag: got %b want 1", ovf2); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf4_flag: got %b want 0", ovf); end
`else
        checks++; if (bcd2 !== 8'h50) begin errors++; $display("FAIL wrap2_bcd: got %h want 50", bcd2); end
`endif
    endtask

    task automatic test_reset_mid;
        int n;
        bit seen;
        sig_period = 10;
        repeat (3) @(negedge clk);
        pulse_start();
        repeat (501) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before: got %b want 1", busy); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", busy); end
        checks++; if (bcd !== 16'h0000) begin errors++; $display("FAIL mid_bcd: got %h want 0000", bcd); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_done: got %b want 0", done); end
        rst  = 1'b1;
        seen = 1'b0;
        repeat (1100) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_done: got %b want 0", seen); end
        pulse_start();
        wait_done(n);
        checks++; if (n != 1002) begin errors++; $display("FAIL mid_restart_latency: got %0d want 1002", n); end
        checks++; if (bcd !== 16'h0100) begin errors++; $display("FAIL mid_restart_bcd: got %h want 0100", bcd); end
    endtask

    task automatic test_back_to_back;
        int n;
        sig_period = 20;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            wait_done(n);
            checks++; if (n != 1002) begin errors++; $display("FAIL b2b_period%0d: got %0d want 1002", i, n); end
            checks++; if (bcd !== 16'h0050) begin errors++; $display("FAIL b2b_bcd%0d: got %h want 0050", i, bcd); end
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy%0d: got %b want 1", i, busy); end
        end
        start = 1'b0;
        wait_done(n);
        checks++; if (n != 1002) begin errors++; $display("FAIL b2b_last_period: got %0d want 1002", n); end
        checks++; if (bcd !== 16'h0050) begin errors++; $display("FAIL b2b_last_bcd: got %h want 0050", bcd); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_last_busy: got %b want 0", busy); end
    endtask

    initial begin
        test_reset();
        test_count();
        test_no_edge();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
